lite_s2mm_mover: RTL

LITE_S2MM_MOVER -- requirements
Module: lite_s2mm_mover

---
 rtl/lite_mover_pkg.sv | 49 ++++
 rtl/lite_s2mm_mover.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lite_mover_pkg.sv
// Shared definitions for the lite S2MM mover: command field layout, status
// byte layout and the controller state encoding.
// Optional feature macro: LITE_S2MM_MOVER_STS_EN (status channel and STS state).
package lite_mover_pkg;

    // Command word layout
    localparam int CMD_W         = 72;
    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_W   = 32;
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_W     = 4;

    // Status byte layout
    localparam int STS_W          = 8;
    localparam int STS_OK_BIT     = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
`ifdef LITE_S2MM_MOVER_STS_EN
        ,
        ST_STS  = 2'd2
`endif
    } mover_state_e;

    // Assemble a status byte from its individual fields.
    function automatic logic [STS_W-1:0] pack_sts(
        input logic                 ok,
        input logic                 slverr,
        input logic                 decerr,
        input logic                 interr,
        input logic [CMD_TAG_W-1:0] tag
    );
        logic [STS_W-1:0] s;
        s = '0;
        s[STS_OK_BIT]     = ok;
        s[STS_SLVERR_BIT] = slverr;
        s[STS_DECERR_BIT] = decerr;
        s[STS_INTERR_BIT] = interr;
        s[STS_TAG_LSB +: CMD_TAG_W] = tag;
        return s;
    endfunction

endpackage

// File: rtl/lite_s2mm_mover.sv
// Lite S2MM mover: accepts one command, writes the matching stream beats into
// a word-addressed memory port, then reports a status byte.
// Optional feature macro: LITE_S2MM_MOVER_STS_EN. When undefined the status
// channel is tied off and the controller returns straight to IDLE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a command, cmd_tready high
// DATA    | accepting stream beats, one memory write per accepted beat
// STS     | presenting the status byte until sts_tready (STS build only)
module lite_s2mm_mover
    import lite_mover_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int BTT_W  = 23
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_axis_s2mm_cmd_tvalid,
    output logic              s_axis_s2mm_cmd_tready,
    input  logic [CMD_W-1:0]  s_axis_s2mm_cmd_tdata,

    input  logic              s_axis_s2mm_tvalid,
    output logic              s_axis_s2mm_tready,
    input  logic [31:0]       s_axis_s2mm_tdata,
    input  logic [3:0]        s_axis_s2mm_tkeep,
    input  logic              s_axis_s2mm_tlast,

    output logic              m_axis_s2mm_sts_tvalid,
    input  logic              m_axis_s2mm_sts_tready,
    output logic [STS_W-1:0]  m_axis_s2mm_sts_tdata,
    output logic              m_axis_s2mm_sts_tkeep,
    output logic              m_axis_s2mm_sts_tlast,

    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy
);

    localparam logic [33:0] MEM_BYTES = 34'(1) << (MEM_AW + 2);

    mover_state_e state_q, state_nxt;

    logic [BTT_W-1:0]       cmd_btt;
    logic [CMD_SADDR_W-1:0] cmd_saddr;
    logic [CMD_TAG_W-1:0]   cmd_tag;
    logic [BTT_W:0]         cmd_btt_p3;
    logic [33:0]            cmd_end;
    logic                   cmd_interr;
    logic                   cmd_decerr;
    logic                   cmd_err;
    logic                   cmd_fire;
    logic                   beat_fire;
    logic                   last_beat;

    logic [CMD_TAG_W-1:0]   tag_q;
    logic [MEM_AW-1:0]      word_addr_q;
    logic [BTT_W-2:0]       beats_q;
    logic                   interr_q;
    logic                   decerr_q;

    logic                   cmd_ready_c;
    logic                   data_ready_c;
    logic                   sts_valid_c;

    // Inline command decode and error classification.
    assign cmd_btt    = s_axis_s2mm_cmd_tdata[CMD_BTT_LSB +: BTT_W];
    assign cmd_saddr  = s_axis_s2mm_cmd_tdata[CMD_SADDR_LSB +: CMD_SADDR_W];
    assign cmd_tag    = s_axis_s2mm_cmd_tdata[CMD_TAG_LSB +: CMD_TAG_W];
    assign cmd_btt_p3 = {1'b0, cmd_btt} + (BTT_W+1)'(3);
    // Last byte beyond the top of memory <=> saddr + btt > memory size.
    assign cmd_end    = {2'b00, cmd_saddr} + 34'(cmd_btt);
    assign cmd_interr = (cmd_btt == '0) || (cmd_saddr[1:0] != 2'b00);
    assign cmd_decerr = (cmd_end > MEM_BYTES);
    assign cmd_err    = cmd_interr | cmd_decerr;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{s_axis_s2mm_cmd_tdata[CMD_SADDR_LSB-1:CMD_BTT_LSB+BTT_W],
                               s_axis_s2mm_cmd_tdata[CMD_W-1:CMD_TAG_LSB+CMD_TAG_W]};

    // Handshake-facing outputs are forced low while reset is asserted.
    assign s_axis_s2mm_cmd_tready = cmd_ready_c & ~rst;
    assign s_axis_s2mm_tready     = data_ready_c & ~rst;
    assign busy                   = (state_q != ST_IDLE) & ~rst;

    assign cmd_fire  = s_axis_s2mm_cmd_tready & s_axis_s2mm_cmd_tvalid;
    assign beat_fire = s_axis_s2mm_tready & s_axis_s2mm_tvalid;
    assign last_beat = (beats_q == (BTT_W-1)'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state and handshake enables.
    always_comb begin
        state_nxt    = state_q;
        cmd_ready_c  = 1'b0;
        data_ready_c = 1'b0;
        sts_valid_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (s_axis_s2mm_cmd_tvalid) begin
`ifdef LITE_S2MM_MOVER_STS_EN
                    state_nxt = cmd_err ? ST_STS : ST_DATA;
`else
                    state_nxt = cmd_err ? ST_IDLE : ST_DATA;
`endif
                end
            end
            ST_DATA: begin
                data_ready_c = 1'b1;
                if (s_axis_s2mm_tvalid && (last_beat || s_axis_s2mm_tlast)) begin
`ifdef LITE_S2MM_MOVER_STS_EN
                    state_nxt = ST_STS;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef LITE_S2MM_MOVER_STS_EN
            ST_STS: begin
                sts_valid_c = 1'b1;
                if (m_axis_s2mm_sts_tready) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, beat counting, error flags and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            word_addr_q <= '0;
            beats_q     <= '0;
            interr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            mem_we <= 1'b0;
            if (cmd_fire) begin
                tag_q       <= cmd_tag;
                word_addr_q <= cmd_saddr[MEM_AW+1:2];
                beats_q     <= cmd_btt_p3[BTT_W:2];
                interr_q    <= cmd_interr;
                decerr_q    <= cmd_decerr;
            end
            if (beat_fire) begin
                mem_we      <= 1'b1;
                mem_addr    <= word_addr_q;
                mem_wdata   <= s_axis_s2mm_tdata;
                mem_be      <= s_axis_s2mm_tkeep;
                word_addr_q <= word_addr_q + 1'b1;
                beats_q     <= beats_q - 1'b1;
                // tlast must coincide exactly with the final counted beat.
                if (last_beat != s_axis_s2mm_tlast) interr_q <= 1'b1;
            end
        end
    end

`ifdef LITE_S2MM_MOVER_STS_EN
    // Status byte is a pure function of the latched flags while in STS.
    assign m_axis_s2mm_sts_tvalid = sts_valid_c & ~rst;
    assign m_axis_s2mm_sts_tkeep  = m_axis_s2mm_sts_tvalid;
    assign m_axis_s2mm_sts_tlast  = m_axis_s2mm_sts_tvalid;
    assign m_axis_s2mm_sts_tdata  = m_axis_s2mm_sts_tvalid ?
        pack_sts(~(interr_q | decerr_q), 1'b0, decerr_q, interr_q, tag_q) : '0;
`else
    logic unused_sts;
    assign unused_sts = ^{sts_valid_c, m_axis_s2mm_sts_tready, tag_q, interr_q, decerr_q};
    assign m_axis_s2mm_sts_tvalid = 1'b0;
    assign m_axis_s2mm_sts_tkeep  = 1'b0;
    assign m_axis_s2mm_sts_tlast  = 1'b0;
    assign m_axis_s2mm_sts_tdata  = '0;
`endif

endmodule
